mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Sequences the single shared main-memory port between the instruction-cache miss path (read-only) and the data-cache miss/writeback path (read/write). Sits between the two cache controllers and the memory model, below `proc` in `proc_hier`. Accepts one outstanding transaction at a time and arbitrates fairly under contention. Keeps saturating grant and conflict counters for the perf bench.

## Interface
- `MEM_AW`, default 16: memory address width.
- `MEM_DW`, default 16: memory data width.
- `CNT_W`, default 16: width of the perf counters.
- `clk` input 1: the only clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-low reset (asserted when 0).
- `i_req` input 1: I-side request; held high until `i_done`.
- `i_addr` input MEM_AW: I-side read address; stable while `i_req`.
- `i_done` output 1: one-cycle pulse; `rdata` is valid for the I-side.
- `d_req` input 1: D-side request; held high until `d_done`.
- `d_wr` input 1: D-side is a write (1) or a read (0); stable while `d_req`.
- `d_addr` input MEM_AW: D-side address.
- `d_wdata` input MEM_DW: D-side write data.
- `d_done` output 1: one-cycle pulse; the D write has completed, or `rdata` is valid for the D-side.
- `rdata` output MEM_DW: registered read data for the current done.
- `mem_req` output 1: one-cycle issue strobe to memory.
- `mem_wr` output 1: write enable; valid with `mem_req`.
- `mem_addr` output MEM_AW: latched address.
- `mem_wdata` output MEM_DW: latched write data.
- `mem_done` input 1: memory completion pulse. Never asserted in the same cycle as `mem_req`.
- `mem_rdata` input MEM_DW: read data; valid with `mem_done`.
- `grant_i_cnt` output CNT_W: number of I grants.
- `grant_d_cnt` output CNT_W: number of D grants.
- `conflict_cnt` output CNT_W: number of cycles in which both sides were eligible in IDLE.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - Eligible requesters are those with `req` high and not masked by `cool`.
  - If none are eligible, stay in IDLE.
  - If exactly one is eligible, grant it.
  - If both are eligible, grant the side not granted last (register `last_d`; reset value 1, so the first conflict goes to I). Increment `conflict_cnt`.
  - On grant:
    - Latch `owner`, `wr`, `addr` and `wdata` (I-side: wr=0, wdata=0).
    - Increment that side's grant counter.
    - Go to ISSUE.
- **ISSUE**: drive `mem_req`=1 with the latched fields for exactly one cycle, then go to WAIT.
- **WAIT**: hold `mem_addr`, `mem_wr` and `mem_wdata`. On `mem_done`, capture `mem_rdata` into `rdata` (writes capture as well; the value is don't-care) and go to RESP. There is no timeout.
- **RESP**:
  - Pulse the owner's done for one cycle.
  - `rdata` holds its value until the next capture.
  - Set `cool` to the owner for the next IDLE cycle only, which masks that side's still-high `req` so it is not re-granted.
  - Go to IDLE.
- Reaching ISSUE requires a grant, so a `mem_done` arriving in IDLE or ISSUE is a protocol error. It is ignored, and the bench flags it.
- Counters saturate at all-ones and do not wrap.
- Changes on a requester's inputs while it is not the owner have no effect. The owner's inputs are not re-sampled after the grant.

## Timing
- **Reset** (asynchronous, `rst`=0): state becomes IDLE, and `last_d`=1. Everything else goes to 0: `cool`, `i_done`, `d_done`, `rdata`, all `mem_*` outputs, and all counters. An in-flight memory transaction is abandoned; memory shares `rst`.
- **Minimum latency**, with `req` first high in cycle 0 and memory answering one cycle after issue:
  - cycle 1: ISSUE, `mem_req`=1.
  - cycle 2: `mem_done`.
  - cycle 3: done pulse.
- The general latency is 3 + (mem latency − 1) cycles.
- **Back-to-back same side**: after done in cycle n, the next grant is in cycle n+2 at the earliest, because of the `cool` cycle. The other side can be granted in cycle n+1.
- **Simultaneous first requests after reset**: I is granted, then D, then the grants alternate.
- **Request dropped by its owner mid-transaction**: the transaction still completes and the done still pulses.

## Structure
- Package `mem_arb_pkg` holds:
  - the state encoding (`ARB_IDLE`, `ARB_ISSUE`, `ARB_WAIT`, `ARB_RESP`, 2 bits);
  - owner encoding `OWN_I`=0, `OWN_D`=1;
  - default widths.
- Sub-module `sat_counter`, parameterised by width, with `clk`, `rst` and `inc` inputs and a `count` output. It is instantiated three times.
- The FSM, the arbitration logic and the latches live in `mem_arbiter`.

## Test plan
- **Single I read**: `i_req`, `i_addr`=0x0040; memory returns 0xBEEF one cycle after `mem_req`.
  - Required: `mem_req` in cycle 1 with `mem_wr`=0 and `mem_addr`=0x0040; `i_done` in cycle 3 with `rdata`=0xBEEF; `grant_i_cnt`=1.
- **D write**: `d_req`, `d_wr`=1, `d_addr`=0x1234, `d_wdata`=0x5A5A, memory latency 4.
  - Required: `mem_wr`=1 and `mem_wdata`=0x5A5A held through WAIT; `d_done` in cycle 6; `i_done` never pulses.
- **Contention**: `i_req` and `d_req` both held continuously for 4 transactions.
  - Required: grant order I, D, I, D; `conflict_cnt` ≥2; each done goes only to its owner.
- **Cool mask**: `d_req` held high one cycle past `d_done` with `i_req` low.
  - Required: no grant in the cycle after `d_done`. The next D grant only happens if `d_req` is still high in cycle n+2.
- **Reset mid-WAIT**: assert `rst`=0 during WAIT.
  - Required: all outputs 0 immediately (asynchronously); after release, the FSM is in IDLE and the next conflict grants I.
- **Saturation**: force `grant_d_cnt` to 0xFFFE, then perform 3 D grants.
  - Required: the counter reads 0xFFFF and holds there.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: state/owner encodings and default widths for the memory-port arbiter
package mem_arb_pkg;
    localparam int MEM_AW_DEF = 16;
    localparam int MEM_DW_DEF = 16;
    localparam int CNT_W_DEF  = 16;
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arbState_t;
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter
    import mem_arb_pkg::*;
#(
    parameter int W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else if (inc && count != '1)
            count <= count + 1'b1;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between I-cache reads and D-cache reads/writes,
// one transaction at a time, alternating under contention
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_AW = MEM_AW_DEF,
    parameter int MEM_DW = MEM_DW_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [MEM_AW-1:0] i_addr,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [MEM_AW-1:0] d_addr,
    input  logic [MEM_DW-1:0] d_wdata,
    output logic              d_done,
    output logic [MEM_DW-1:0] rdata,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [MEM_DW-1:0] mem_wdata,
    input  logic              mem_done,
    input  logic [MEM_DW-1:0] mem_rdata,
    output logic [CNT_W-1:0]  grant_i_cnt,
    output logic [CNT_W-1:0]  grant_d_cnt,
    output logic [CNT_W-1:0]  conflict_cnt
);
    arbState_t state, nextState;
    owner_t    owner;
    logic      lastD, coolI, coolD;
    logic      idle, iElig, dElig, grant, grantD;

    always_comb begin
        idle   = state == ARB_IDLE;
        iElig  = i_req & ~coolI;
        dElig  = d_req & ~coolD;
        grant  = iElig | dElig;
        // under contention D wins only if I was granted last
        grantD = dElig & (~iElig | ~lastD);
    end

    always_comb begin
        nextState = state;
        mem_req   = 1'b0;
        i_done    = 1'b0;
        d_done    = 1'b0;
        case (state)
            ARB_IDLE:  nextState = grant ? ARB_ISSUE : ARB_IDLE;
            ARB_ISSUE: begin
                mem_req   = 1'b1;
                nextState = ARB_WAIT;
            end
            ARB_WAIT:  nextState = mem_done ? ARB_RESP : ARB_WAIT;
            ARB_RESP:  begin
                i_done    = owner == OWN_I;
                d_done    = owner == OWN_D;
                nextState = ARB_IDLE;
            end
            default:   nextState = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ARB_IDLE;
            owner     <= OWN_I;
            lastD     <= 1'b1;
            coolI     <= 1'b0;
            coolD     <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
        end else begin
            state <= nextState;
            // mask the just-served side for exactly the following IDLE cycle
            coolI <= state == ARB_RESP && owner == OWN_I;
            coolD <= state == ARB_RESP && owner == OWN_D;
            if (idle && grant) begin
                owner     <= grantD ? OWN_D : OWN_I;
                lastD     <= grantD;
                mem_wr    <= grantD & d_wr;
                mem_addr  <= grantD ? d_addr : i_addr;
                mem_wdata <= grantD ? d_wdata : '0;
            end
            if (state == ARB_WAIT && mem_done)
                rdata <= mem_rdata;
        end
    end

    sat_counter #(.W(CNT_W)) uGrantI (
        .clk   (clk),
        .rst   (rst),
        .inc   (idle & grant & ~grantD),
        .count (grant_i_cnt)
    );

    sat_counter #(.W(CNT_W)) uGrantD (
        .clk   (clk),
        .rst   (rst),
        .inc   (idle & grantD),
        .count (grant_d_cnt)
    );

    sat_counter #(.W(CNT_W)) uConflict (
        .clk   (clk),
        .rst   (rst),
        .inc   (idle & iElig & dElig),
        .count (conflict_cnt)
    );
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios against mem_arbiter with a behavioural memory of programmable latency
module tb_mem_arbiter;
    logic        clk, rst;
    logic        i_req, i_done, d_req, d_wr, d_done;
    logic [15:0] i_addr, d_addr, d_wdata, rdata;
    logic        mem_req, mem_wr, mem_done;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic [15:0] grant_i_cnt, grant_d_cnt, conflict_cnt;
    int          tests, fails;
    int          memLat;
    logic [15:0] memData;

    mem_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_done       (i_done),
        .d_req        (d_req),
        .d_wr         (d_wr),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_done       (d_done),
        .rdata        (rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_done     (mem_done),
        .mem_rdata    (mem_rdata),
        .grant_i_cnt  (grant_i_cnt),
        .grant_d_cnt  (grant_d_cnt),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory answers memLat cycles after the issue strobe with memData ^ address
    initial begin
        int memCnt;
        memCnt    = 0;
        mem_done  = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_done = 1'b0;
            if (!rst)
                memCnt = 0;
            else if (mem_req)
                memCnt = memLat;
            else if (memCnt > 0) begin
                memCnt--;
                if (memCnt == 0) begin
                    mem_done  = 1'b1;
                    mem_rdata = memData ^ mem_addr;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit side, output int cyc);
        cyc = -1;
        for (int k = 1; k <= 30; k++) begin
            step();
            if ((side ? d_done : i_done) === 1'b1) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        i_req = 0; d_req = 0; d_wr = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        memLat = 1; memData = '0;
        step();
        step();
        tests++;
        if ({mem_req, mem_wr, mem_addr, mem_wdata, rdata, i_done, d_done} !== '0) begin
            fails++;
            $display("FAIL reset_outputs got req=%0b wr=%0b addr=%h wdata=%h rdata=%h idone=%0b ddone=%0b exp all 0",
                     mem_req, mem_wr, mem_addr, mem_wdata, rdata, i_done, d_done);
        end
        tests++;
        if ({grant_i_cnt, grant_d_cnt, conflict_cnt} !== '0) begin
            fails++;
            $display("FAIL reset_counters got %h %h %h exp 0 0 0", grant_i_cnt, grant_d_cnt, conflict_cnt);
        end
        rst = 1'b1;
        step();
        tests++;
        if (mem_req !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle mem_req got %0b exp 0", mem_req);
        end
    endtask

    task automatic test_single_i_read();
        memLat = 1; memData = 16'hBEAF;
        i_addr = 16'h0040; i_req = 1;
        step();
        tests++;
        if ({mem_req, mem_wr, mem_addr} !== {1'b1, 1'b0, 16'h0040}) begin
            fails++;
            $display("FAIL single_i_issue got req=%0b wr=%0b addr=%h exp 1 0 0040", mem_req, mem_wr, mem_addr);
        end
        step();
        tests++;
        if (i_done !== 1'b0) begin
            fails++;
            $display("FAIL single_i_early_done got %0b exp 0", i_done);
        end
        step();
        tests++;
        if ({i_done, d_done, rdata} !== {1'b1, 1'b0, 16'hBEEF}) begin
            fails++;
            $display("FAIL single_i_done got idone=%0b ddone=%0b rdata=%h exp 1 0 beef", i_done, d_done, rdata);
        end
        i_req = 0;
        tests++;
        if (grant_i_cnt !== 16'd1) begin
            fails++;
            $display("FAIL single_i_grant_cnt got %0d exp 1", grant_i_cnt);
        end
        step();
        step();
    endtask

    task automatic test_d_write();
        bit iSeen;
        iSeen = 0;
        memLat = 4; memData = 16'h1111;
        d_wr = 1; d_addr = 16'h1234; d_wdata = 16'h5A5A; d_req = 1;
        for (int c = 1; c <= 6; c++) begin
            step();
            if (i_done === 1'b1) iSeen = 1;
            if (c == 1) begin
                tests++;
                if ({mem_req, mem_addr} !== {1'b1, 16'h1234}) begin
                    fails++;
                    $display("FAIL d_write_issue got req=%0b addr=%h exp 1 1234", mem_req, mem_addr);
                end
            end
            if (c < 6) begin
                tests++;
                if ({mem_wr, mem_wdata, d_done} !== {1'b1, 16'h5A5A, 1'b0}) begin
                    fails++;
                    $display("FAIL d_write_hold cycle %0d got wr=%0b wdata=%h ddone=%0b exp 1 5a5a 0", c, mem_wr, mem_wdata, d_done);
                end
            end else begin
                tests++;
                if (d_done !== 1'b1) begin
                    fails++;
                    $display("FAIL d_write_done got %0b exp 1 in cycle 6", d_done);
                end
            end
        end
        d_req = 0;
        tests++;
        if (iSeen !== 1'b0) begin
            fails++;
            $display("FAIL d_write_i_done got pulse exp none");
        end
        tests++;
        if (grant_d_cnt !== 16'd1) begin
            fails++;
            $display("FAIL d_write_grant_cnt got %0d exp 1", grant_d_cnt);
        end
        step();
        step();
    endtask

    task automatic test_contention();
        logic [3:0] order;
        int n, cyc;
        n = 0; order = '0;
        memLat = 1; memData = '0;
        i_addr = 16'h0100; d_addr = 16'h0200; d_wr = 0;
        i_req = 1; d_req = 1;
        for (int k = 0; k < 40 && n < 4; k++) begin
            step();
            if (i_done === 1'b1 && d_done === 1'b1) begin
                tests++; fails++;
                $display("FAIL contention_both_done got both pulses exp one");
            end
            if (i_done === 1'b1 && n < 4) begin
                order[n] = 1'b0; n++;
                tests++;
                if (rdata !== 16'h0100) begin
                    fails++;
                    $display("FAIL contention_i_rdata got %h exp 0100", rdata);
                end
            end else if (d_done === 1'b1 && n < 4) begin
                order[n] = 1'b1; n++;
                tests++;
                if (rdata !== 16'h0200) begin
                    fails++;
                    $display("FAIL contention_d_rdata got %h exp 0200", rdata);
                end
            end
        end
        i_req = 0; d_req = 0;
        tests++;
        if (n !== 4 || order !== 4'b1010) begin
            fails++;
            $display("FAIL contention_order got %0d dones order(lsb first)=%b exp 4 dones 1010", n, order);
        end
        step();
        step();
        i_req = 1; d_req = 1;
        step();
        tests++;
        if ({mem_req, mem_addr} !== {1'b1, 16'h0100}) begin
            fails++;
            $display("FAIL contention_regrant got req=%0b addr=%h exp 1 0100", mem_req, mem_addr);
        end
        tests++;
        if (conflict_cnt !== 16'd2) begin
            fails++;
            $display("FAIL contention_conflict_cnt got %0d exp 2", conflict_cnt);
        end
        d_req = 0;
        wait_done(0, cyc);
        i_req = 0;
        tests++;
        if (cyc !== 2) begin
            fails++;
            $display("FAIL contention_last_done got cycle %0d exp 2", cyc);
        end
        step();
        step();
    endtask

    task automatic test_cool_mask();
        int cyc;
        memLat = 1; memData = '0;
        d_wr = 0; d_addr = 16'h0300; d_req = 1;
        wait_done(1, cyc);
        tests++;
        if (cyc !== 3) begin
            fails++;
            $display("FAIL cool_first_done got cycle %0d exp 3", cyc);
        end
        step();
        step();
        d_req = 0;
        tests++;
        if (mem_req !== 1'b0) begin
            fails++;
            $display("FAIL cool_mask_issue got %0b exp 0", mem_req);
        end
        step();
        tests++;
        if (mem_req !== 1'b0 || grant_d_cnt !== 16'd4) begin
            fails++;
            $display("FAIL cool_no_regrant got req=%0b gd=%0d exp 0 4", mem_req, grant_d_cnt);
        end
        d_req = 1;
        wait_done(1, cyc);
        step();
        step();
        tests++;
        if (mem_req !== 1'b0) begin
            fails++;
            $display("FAIL cool_mask_n2 got %0b exp 0", mem_req);
        end
        step();
        tests++;
        if (mem_req !== 1'b1 || grant_d_cnt !== 16'd6) begin
            fails++;
            $display("FAIL cool_regrant_n3 got req=%0b gd=%0d exp 1 6", mem_req, grant_d_cnt);
        end
        d_req = 0;
        wait_done(1, cyc);
        tests++;
        if (cyc !== 2) begin
            fails++;
            $display("FAIL dropped_req_done got cycle %0d exp 2", cyc);
        end
        step();
        step();
    endtask

    task automatic test_reset_mid_wait();
        int cyc;
        memLat = 10; memData = '0;
        i_addr = 16'h0777; i_req = 1;
        step();
        step();
        #3;
        rst = 1'b0;
        #1;
        tests++;
        if ({mem_req, mem_wr, mem_addr, mem_wdata, rdata, i_done, d_done} !== '0) begin
            fails++;
            $display("FAIL reset_async_outputs got req=%0b wr=%0b addr=%h wdata=%h rdata=%h exp all 0",
                     mem_req, mem_wr, mem_addr, mem_wdata, rdata);
        end
        tests++;
        if ({grant_i_cnt, grant_d_cnt, conflict_cnt} !== '0) begin
            fails++;
            $display("FAIL reset_async_counters got %h %h %h exp 0 0 0", grant_i_cnt, grant_d_cnt, conflict_cnt);
        end
        i_req = 0;
        step();
        step();
        rst = 1'b1;
        memLat = 1;
        step();
        i_addr = 16'h0100; d_addr = 16'h0200; d_wr = 0;
        i_req = 1; d_req = 1;
        step();
        tests++;
        if ({mem_req, mem_addr, conflict_cnt, grant_i_cnt} !== {1'b1, 16'h0100, 16'd1, 16'd1}) begin
            fails++;
            $display("FAIL reset_first_conflict got req=%0b addr=%h conf=%0d gi=%0d exp 1 0100 1 1",
                     mem_req, mem_addr, conflict_cnt, grant_i_cnt);
        end
        d_req = 0;
        wait_done(0, cyc);
        i_req = 0;
        tests++;
        if (cyc !== 2) begin
            fails++;
            $display("FAIL reset_after_done got cycle %0d exp 2", cyc);
        end
        step();
        step();
    endtask

    task automatic test_saturation();
        int cyc;
        memLat = 1; memData = '0;
        force dut.uGrantD.count = 16'hFFFE;
        step();
        release dut.uGrantD.count;
        step();
        tests++;
        if (grant_d_cnt !== 16'hFFFE) begin
            fails++;
            $display("FAIL sat_preload got %h exp fffe", grant_d_cnt);
        end
        d_wr = 0; d_addr = 16'h0400;
        for (int t = 0; t < 3; t++) begin
            d_req = 1;
            wait_done(1, cyc);
            d_req = 0;
            tests++;
            if (cyc !== 3 || grant_d_cnt !== 16'hFFFF) begin
                fails++;
                $display("FAIL sat_grant_%0d got cycle=%0d cnt=%h exp 3 ffff", t, cyc, grant_d_cnt);
            end
            step();
            step();
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_single_i_read();
        test_d_write();
        test_contention();
        test_cool_mask();
        test_reset_mid_wait();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
